// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the accumulator tuning word from a start word
// to a stop word with a programmable dwell, in single, repeat or ping-pong mode.
module freq_sweep_ctrl #(
    parameter int ACC_SIZE = 28,
    parameter int DWELL_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ACC_SIZE-1:0] cfg_start_word,
    input  logic [ACC_SIZE-1:0] cfg_stop_word,
    input  logic [ACC_SIZE-1:0] cfg_step,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [1:0]          cfg_mode,
    input  logic                start,
    input  logic                abort,
    output logic [ACC_SIZE-1:0] freq_word,
    output logic                phase_clr,
    output logic                busy,
    output logic                pass_done
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t state, state_nxt;

    logic [ACC_SIZE-1:0] start_sh, stop_sh, step_sh;
    logic [DWELL_W-1:0]  dwell_sh;
    logic [1:0]          mode_sh;

    logic [ACC_SIZE-1:0] target, target_nxt, freq_nxt, turn_target;
    logic [DWELL_W-1:0]  cnt, cnt_nxt;
    logic                up, up_nxt;
    logic                busy_nxt, clr_nxt, pd_nxt;

    // Step toward tgt; any overshoot, ACC_SIZE overflow/underflow or zero step clamps to tgt.
    function automatic logic [ACC_SIZE-1:0] step_word(
        input logic [ACC_SIZE-1:0] cur,
        input logic [ACC_SIZE-1:0] stp,
        input logic [ACC_SIZE-1:0] tgt,
        input logic                dir_up
    );
        logic [ACC_SIZE:0] sum;
        if (stp == '0)
            return tgt;
        if (dir_up) begin
            sum = {1'b0, cur} + {1'b0, stp};
            if (sum[ACC_SIZE] || (sum[ACC_SIZE-1:0] > tgt))
                return tgt;
        end else begin
            sum = {1'b0, cur} - {1'b0, stp};
            if (sum[ACC_SIZE] || (sum[ACC_SIZE-1:0] < tgt))
                return tgt;
        end
        return sum[ACC_SIZE-1:0];
    endfunction

    assign cfg_ready   = (state == IDLE);
    assign turn_target = (target == stop_sh) ? start_sh : stop_sh;

    always_comb begin
        state_nxt  = state;
        freq_nxt   = freq_word;
        cnt_nxt    = cnt;
        target_nxt = target;
        up_nxt     = up;
        busy_nxt   = busy;
        clr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SWEEP;
                    freq_nxt   = start_sh;
                    cnt_nxt    = '0;
                    target_nxt = stop_sh;
                    up_nxt     = (start_sh < stop_sh);
                    busy_nxt   = 1'b1;
                    clr_nxt    = 1'b1;
                end
            end
            SWEEP: begin
                if (cnt == dwell_sh) begin
                    cnt_nxt = '0;
                    if (freq_word != target) begin
                        freq_nxt = step_word(freq_word, step_sh, target, up);
                    end else begin
                        case (mode_sh)
                            2'd1: freq_nxt = start_sh;
                            2'd2: begin
                                // Turn around at the endpoint without dwelling on it again.
                                target_nxt = turn_target;
                                up_nxt     = ~up;
                                freq_nxt   = step_word(freq_word, step_sh, turn_target, ~up);
                            end
                            default: begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                            end
                        endcase
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) begin
            state_nxt = IDLE;
            freq_nxt  = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            clr_nxt   = 1'b0;
        end

        // Registered so it is high during the last dwell cycle of an endpoint word.
        pd_nxt = (state_nxt == SWEEP) && (freq_nxt == target_nxt) && (cnt_nxt == dwell_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            freq_word <= '0;
            cnt       <= '0;
            target    <= '0;
            up        <= 1'b0;
            busy      <= 1'b0;
            phase_clr <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            freq_word <= freq_nxt;
            cnt       <= cnt_nxt;
            target    <= target_nxt;
            up        <= up_nxt;
            busy      <= busy_nxt;
            phase_clr <= clr_nxt;
            pass_done <= pd_nxt;
        end
    end

    // A sweep starting in the same cycle still sees the previous shadow values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sh <= '0;
            stop_sh  <= '0;
            step_sh  <= '0;
            dwell_sh <= '0;
            mode_sh  <= '0;
        end else if (cfg_valid && cfg_ready) begin
            start_sh <= cfg_start_word;
            stop_sh  <= cfg_stop_word;
            step_sh  <= cfg_step;
            dwell_sh <= cfg_dwell;
            mode_sh  <= cfg_mode;
        end
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed testbench for freq_sweep_ctrl with hand-computed tuning-word sequences.
module tb_freq_sweep_ctrl;

    localparam int ACC_SIZE = 28;
    localparam int DWELL_W  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [ACC_SIZE-1:0] cfg_start_word = '0;
    logic [ACC_SIZE-1:0] cfg_stop_word = '0;
    logic [ACC_SIZE-1:0] cfg_step = '0;
    logic [DWELL_W-1:0]  cfg_dwell = '0;
    logic [1:0]          cfg_mode = '0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ACC_SIZE-1:0] freq_word;
    logic                phase_clr;
    logic                busy;
    logic                pass_done;

    int pass_cnt = 0;
    int total    = 0;
    int exp_q[$];
    bit pd_q[$];

    freq_sweep_ctrl #(.ACC_SIZE(ACC_SIZE), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_word(cfg_start_word), .cfg_stop_word(cfg_stop_word),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort), .freq_word(freq_word),
        .phase_clr(phase_clr), .busy(busy), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int sw, input int pw, input int st, input int dw, input int md);
        cfg_start_word = sw[ACC_SIZE-1:0];
        cfg_stop_word  = pw[ACC_SIZE-1:0];
        cfg_step       = st[ACC_SIZE-1:0];
        cfg_dwell      = dw[DWELL_W-1:0];
        cfg_mode       = md[1:0];
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Index 0 is the first cycle after start, so phase_clr is expected only there.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), 32'(freq_word), 32'(exp_q[i]));
            chk($sformatf("%s_pd%0d", tag, i), 32'(pass_done), 32'(pd_q[i]));
            chk($sformatf("%s_clr%0d", tag, i), 32'(phase_clr), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        #3;
        chk("rst_word", 32'(freq_word), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clr", 32'(phase_clr), 32'd0);
        chk("rst_pd", 32'(pass_done), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single up sweep, dwell 1
        do_cfg(100, 130, 10, 1, 0);
        go();
        exp_q = '{100, 100, 110, 110, 120, 120, 130, 130};
        pd_q  = '{0, 0, 0, 0, 0, 0, 0, 1};
        chk("single_ready", 32'(cfg_ready), 32'd0);
        sweep_check("single");
        chk("single_end_busy", 32'(busy), 32'd0);
        chk("single_end_word", 32'(freq_word), 32'd130);
        chk("single_end_pd", 32'(pass_done), 32'd0);
        chk("single_end_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("single_hold_word", 32'(freq_word), 32'd130);

        // Overshoot clamp going up
        do_cfg(0, 25, 10, 0, 3);
        go();
        exp_q = '{0, 10, 20, 25};
        pd_q  = '{0, 0, 0, 1};
        sweep_check("clamp");
        chk("clamp_end_busy", 32'(busy), 32'd0);
        chk("clamp_end_word", 32'(freq_word), 32'd25);

        // Down sweep
        do_cfg(50, 20, 15, 0, 0);
        go();
        exp_q = '{50, 35, 20};
        pd_q  = '{0, 0, 1};
        sweep_check("down");
        chk("down_end_busy", 32'(busy), 32'd0);
        chk("down_end_word", 32'(freq_word), 32'd20);

        // Top of range: must clamp, never wrap
        do_cfg(268435436, 268435455, 15, 0, 0);
        go();
        exp_q = '{268435436, 268435451, 268435455};
        pd_q  = '{0, 0, 1};
        sweep_check("top");
        chk("top_end_busy", 32'(busy), 32'd0);
        chk("top_end_word", 32'(freq_word), 32'd268435455);

        // Ping-pong, then abort
        do_cfg(0, 20, 10, 0, 2);
        go();
        exp_q = '{0, 10, 20, 10, 0, 10, 20, 10, 0};
        pd_q  = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
        sweep_check("pp");
        chk("pp_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("pp_abort_word", 32'(freq_word), 32'd0);
        chk("pp_abort_busy", 32'(busy), 32'd0);
        chk("pp_abort_pd", 32'(pass_done), 32'd0);

        // Repeat mode
        do_cfg(5, 7, 1, 0, 1);
        go();
        exp_q = '{5, 6, 7, 5, 6, 7};
        pd_q  = '{0, 0, 1, 0, 0, 1};
        sweep_check("rep");
        chk("rep_word", 32'(freq_word), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rep_abort_busy", 32'(busy), 32'd0);

        // Abort mid-dwell
        do_cfg(100, 200, 10, 5, 0);
        go();
        tick();
        tick();
        chk("mid_word", 32'(freq_word), 32'd100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("mid_abort_word", 32'(freq_word), 32'd0);
        chk("mid_abort_busy", 32'(busy), 32'd0);
        chk("mid_abort_pd", 32'(pass_done), 32'd0);

        // Abort together with start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        chk("abst_clr", 32'(phase_clr), 32'd0);
        chk("abst_word", 32'(freq_word), 32'd0);
        tick();
        chk("abst_busy2", 32'(busy), 32'd0);

        // Asynchronous reset mid-sweep
        go();
        tick();
        chk("prerst_word", 32'(freq_word), 32'd100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", 32'(freq_word), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pd", 32'(pass_done), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Config in the same cycle as start: old config is swept
        do_cfg(300, 310, 10, 0, 0);
        cfg_start_word = 28'd500;
        cfg_stop_word  = 28'd510;
        cfg_valid      = 1'b1;
        start          = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("same_word0", 32'(freq_word), 32'd300);
        tick();
        chk("same_word1", 32'(freq_word), 32'd310);
        chk("same_pd1", 32'(pass_done), 32'd1);
        tick();
        chk("same_busy_end", 32'(busy), 32'd0);
        go();
        chk("new_cfg_word", 32'(freq_word), 32'd500);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
